mem_port_arbiter: RTL and testbench

- Shares the CPU's single external memory port between two requesters: the instruction prefetcher (16-bit fetches) and the scheduler's data path (8/16-bit loads and stores).
- Issues one transaction at a time on a valid/ready port.
- Records every read in a small in-order message FIFO of 2-bit message types, and uses it to route returned data to the correct requester.
- Supports prefetch flush: responses for in-flight fetches are dropped after a branch.

---
 rtl/mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between the instruction prefetcher and the
// data path. Only one transaction is presented at a time. Every read is noted
// in a small in-order message FIFO so that returning data can be steered to
// the requester that issued it. A prefetch flush turns every queued fetch into
// a discard marker, so fetches issued before a branch never reach the core.

module mem_port_arbiter #(
    parameter int ADDR_BITS  = 16,
    parameter int DEPTH      = 4,
    parameter int MAX_STREAK = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pf_req,
    input  logic [ADDR_BITS-1:0]         pf_addr,
    input  logic                         pf_flush,
    output logic                         pf_ack,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic                         d_wide,
    input  logic [ADDR_BITS-1:0]         d_addr,
    input  logic [15:0]                  d_wdata,
    output logic                         d_ack,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_BITS-1:0]         mem_addr,
    output logic                         mem_we,
    output logic                         mem_wide,
    output logic [15:0]                  mem_wdata,
    input  logic                         rsp_valid,
    input  logic [15:0]                  rsp_data,
    output logic                         pf_rvalid,
    output logic [15:0]                  pf_rdata,
    output logic                         d_rvalid,
    output logic [15:0]                  d_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         rsp_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [SW-1:0] STREAK_C = SW'(MAX_STREAK);
    localparam logic [PW-1:0] LAST_C   = PW'(DEPTH - 1);

    // Message types held in the FIFO, one per outstanding read
    typedef enum logic [1:0] {
        MSG_PF         = 2'd0,
        MSG_PF_DISCARD = 2'd1,
        MSG_RD         = 2'd2
    } msg_t;

    // FIFO storage and bookkeeping
    msg_t              type_r [DEPTH];
    logic              wide_r [DEPTH];
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic [SW-1:0]     streak_r;

    // Arbitration and routing decisions for the current cycle
    logic              port_free_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              pf_elig_s;
    logic              d_elig_s;
    logic              pf_grant_s;
    logic              d_grant_s;
    logic              push_s;
    logic              pop_s;
    msg_t              push_type_s;
    logic              push_wide_s;
    msg_t              head_type_s;
    logic              head_wide_s;
    msg_t              head_eff_s;
    logic              route_pf_s;
    logic              route_d_s;

    // Circular pointer advance that also works for non power-of-two depths
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == LAST_C) begin
            return PW'(0);
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign port_free_s  = !mem_valid || mem_ready;
    assign fifo_full_s  = (count_r >= DEPTH_C);
    assign fifo_empty_s = (count_r == CW'(0));
    assign pf_elig_s    = pf_req && !pf_flush && !fifo_full_s;
    assign d_elig_s     = d_req && (d_we || !fifo_full_s);

    // Pick at most one winner; data normally wins unless the prefetcher has
    // been starved for the maximum streak
    always_comb begin
        pf_grant_s = 1'b0;
        d_grant_s  = 1'b0;
        if (reset) begin
            pf_grant_s = 1'b0;
            d_grant_s  = 1'b0;
        end else if (port_free_s) begin
            if (pf_elig_s && (!d_elig_s || (streak_r == STREAK_C))) begin
                pf_grant_s = 1'b1;
            end else if (d_elig_s) begin
                d_grant_s = 1'b1;
            end else begin
                pf_grant_s = 1'b0;
                d_grant_s  = 1'b0;
            end
        end else begin
            pf_grant_s = 1'b0;
            d_grant_s  = 1'b0;
        end
    end

    assign pf_ack      = pf_grant_s;
    assign d_ack       = d_grant_s;
    assign push_s      = pf_grant_s || (d_grant_s && !d_we);
    assign push_type_s = pf_grant_s ? MSG_PF : MSG_RD;
    assign push_wide_s = pf_grant_s ? 1'b1 : d_wide;
    assign pop_s       = rsp_valid && !fifo_empty_s;
    assign head_type_s = type_r[rd_ptr_r];
    assign head_wide_s = wide_r[rd_ptr_r];
    assign outstanding = count_r;

    // A fetch popped in the same cycle as a flush is dropped like the rest
    always_comb begin
        head_eff_s = head_type_s;
        if (pf_flush && (head_type_s == MSG_PF)) begin
            head_eff_s = MSG_PF_DISCARD;
        end else begin
            head_eff_s = head_type_s;
        end
    end

    // Decide which requester (if any) receives the response being popped
    always_comb begin
        route_pf_s = 1'b0;
        route_d_s  = 1'b0;
        case (head_eff_s)
            MSG_PF: begin
                route_pf_s = pop_s;
            end
            MSG_RD: begin
                route_d_s = pop_s;
            end
            default: begin
                route_pf_s = 1'b0;
                route_d_s  = 1'b0;
            end
        endcase
    end

    // Message FIFO contents: flush retags fetches, then a new read is written.
    // Stale slots may be retagged too; they are overwritten before reuse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_r[i] <= MSG_PF_DISCARD;
                wide_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pf_flush && (type_r[i] == MSG_PF)) begin
                    type_r[i] <= MSG_PF_DISCARD;
                end
            end
            if (push_s) begin
                type_r[wr_ptr_r] <= push_type_s;
                wide_r[wr_ptr_r] <= push_wide_s;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Count consecutive data grants taken while the prefetcher is waiting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_r <= SW'(0);
        end else if (!pf_req || pf_grant_s) begin
            streak_r <= SW'(0);
        end else if (d_grant_s && (streak_r != STREAK_C)) begin
            streak_r <= streak_r + SW'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

    // Memory port register: load the winner, hold while stalled, idle when done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= {ADDR_BITS{1'b0}};
            mem_we    <= 1'b0;
            mem_wide  <= 1'b0;
            mem_wdata <= 16'h0000;
        end else if (pf_grant_s) begin
            mem_valid <= 1'b1;
            mem_addr  <= pf_addr;
            mem_we    <= 1'b0;
            mem_wide  <= 1'b1;
            mem_wdata <= 16'h0000;
        end else if (d_grant_s) begin
            mem_valid <= 1'b1;
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wide  <= d_wide;
            mem_wdata <= d_wdata;
        end else if (port_free_s) begin
            mem_valid <= 1'b0;
        end else begin
            mem_valid <= mem_valid;
        end
    end

    // Registered response routing and the empty-FIFO response error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_rvalid <= 1'b0;
            pf_rdata  <= 16'h0000;
            d_rvalid  <= 1'b0;
            d_rdata   <= 16'h0000;
            rsp_err   <= 1'b0;
        end else begin
            pf_rvalid <= route_pf_s;
            d_rvalid  <= route_d_s;
            rsp_err   <= rsp_valid && fifo_empty_s;
            if (route_pf_s) begin
                pf_rdata <= rsp_data;
            end
            if (route_d_s) begin
                d_rdata <= head_wide_s ? rsp_data : {8'h00, rsp_data[7:0]};
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic, checked by a queue-based reference model and decoupled monitors.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AB    = 16;
    localparam int DEPTH = 4;
    localparam int MAXS  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        pf_req, pf_flush, pf_ack;
    logic [15:0] pf_addr;
    logic        d_req, d_we, d_wide, d_ack;
    logic [15:0] d_addr, d_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_wide;
    logic [15:0] mem_addr, mem_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        pf_rvalid, d_rvalid, rsp_err;
    logic [15:0] pf_rdata, d_rdata;
    logic [2:0]  outstanding;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_BITS(AB), .DEPTH(DEPTH), .MAX_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_flush(pf_flush), .pf_ack(pf_ack),
        .d_req(d_req), .d_we(d_we), .d_wide(d_wide), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wide(mem_wide), .mem_wdata(mem_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .pf_rvalid(pf_rvalid), .pf_rdata(pf_rdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .outstanding(outstanding), .rsp_err(rsp_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: kind 0 = live fetch, 1 = dropped fetch, 2 = load
    typedef struct { int kind; bit wide; } msg_s;
    typedef struct { logic [15:0] addr; bit we; bit wide; logic [15:0] wdata; } txn_s;

    msg_s        m_fifo [$];
    txn_s        mem_q  [$];
    logic [15:0] pf_q   [$];
    logic [15:0] d_q    [$];
    int          m_err_pend = 0;
    bit          m_busy = 1'b0;
    int          m_streak = 0;
    bit          m_pf_g = 1'b0;
    bit          m_d_g = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of the specification's rules applied to the current inputs
    task automatic model_step();
        bit   free, pf_ok, d_ok;
        int   cnt;
        msg_s e;
        free  = !m_busy || mem_ready;
        cnt   = m_fifo.size();
        pf_ok = pf_req && !pf_flush && (cnt < DEPTH);
        d_ok  = d_req && (d_we || (cnt < DEPTH));
        m_pf_g = free && pf_ok && (!d_ok || (m_streak == MAXS));
        m_d_g  = free && d_ok && !m_pf_g;
        chk("pf_ack", 32'(pf_ack), 32'(m_pf_g));
        chk("d_ack", 32'(d_ack), 32'(m_d_g));
        if (pf_flush) begin
            foreach (m_fifo[i]) if (m_fifo[i].kind == 0) m_fifo[i].kind = 1;
        end
        if (rsp_valid) begin
            if (m_fifo.size() == 0) begin
                m_err_pend++;
            end else begin
                e = m_fifo.pop_front();
                if (e.kind == 0) pf_q.push_back(rsp_data);
                else if (e.kind == 2) d_q.push_back(e.wide ? rsp_data : (rsp_data & 16'h00FF));
            end
        end
        if (m_pf_g) begin
            m_fifo.push_back(msg_s'{0, 1'b1});
            mem_q.push_back(txn_s'{pf_addr, 1'b0, 1'b1, 16'h0000});
        end
        if (m_d_g) begin
            if (!d_we) m_fifo.push_back(msg_s'{2, d_wide});
            mem_q.push_back(txn_s'{d_addr, d_we, d_wide, d_wdata});
        end
        if (m_pf_g || m_d_g) m_busy = 1'b1;
        else if (free) m_busy = 1'b0;
        if (!pf_req || m_pf_g) m_streak = 0;
        else if (m_d_g && (m_streak < MAXS)) m_streak++;
    endtask

    task automatic tick();
        #2;
        model_step();
        @(negedge clk);
    endtask

    task automatic drain();
        pf_req = 1'b0; d_req = 1'b0; pf_flush = 1'b0; mem_ready = 1'b1;
        while (m_fifo.size() > 0) begin
            rsp_valid = 1'b1;
            rsp_data  = 16'($urandom);
            tick();
        end
        rsp_valid = 1'b0;
        tick();
        tick();
    endtask

    // Port monitor: the expected transaction must be presented until accepted
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (mem_q.size() > 0) begin
                chk("mem_valid", 32'(mem_valid), 32'd1);
                chk("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
                chk("mem_we", 32'(mem_we), 32'(mem_q[0].we));
                chk("mem_wide", 32'(mem_wide), 32'(mem_q[0].wide));
                if (mem_q[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(mem_q[0].wdata));
                if (mem_ready) void'(mem_q.pop_front());
            end else begin
                chk("mem_idle", 32'(mem_valid), 32'd0);
            end
        end
    end

    // Response monitor: each expected response shows exactly one cycle later
    always @(posedge clk) begin
        #1;
        chk("pf_rvalid", 32'(pf_rvalid), 32'(pf_q.size() > 0));
        if (pf_q.size() > 0) chk("pf_rdata", 32'(pf_rdata), 32'(pf_q.pop_front()));
        chk("d_rvalid", 32'(d_rvalid), 32'(d_q.size() > 0));
        if (d_q.size() > 0) chk("d_rdata", 32'(d_rdata), 32'(d_q.pop_front()));
        chk("rsp_err", 32'(rsp_err), 32'(m_err_pend > 0));
        if (m_err_pend > 0) m_err_pend--;
        chk("outstanding", 32'(outstanding), 32'(m_fifo.size()));
    end

    initial begin
        reset = 1'b1; pf_req = 1'b0; pf_addr = 16'h0; pf_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_wide = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        mem_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_rvalids", 32'({pf_rvalid, d_rvalid, rsp_err}), 32'd0);
        chk("rst_acks", 32'({pf_ack, d_ack}), 32'd0);

        // Single fetch with immediate acceptance and response
        pf_req = 1'b1; pf_addr = 16'h0100;
        #1 chk("t1_pf_ack", 32'(pf_ack), 32'd1);
        tick(); pf_req = 1'b0;
        chk("t1_mem_valid", 32'(mem_valid), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0100);
        chk("t1_mem_wide", 32'(mem_wide), 32'd1);
        tick();
        rsp_valid = 1'b1; rsp_data = 16'hBEEF; tick(); rsp_valid = 1'b0;
        chk("t1_pf_rvalid", 32'(pf_rvalid), 32'd1);
        chk("t1_pf_rdata", 32'(pf_rdata), 32'hBEEF);
        chk("t1_outstanding", 32'(outstanding), 32'd0);
        tick();

        // Data beats prefetch; narrow load zero-extends
        pf_req = 1'b1; pf_addr = 16'h0200;
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 16'h0020;
        #1 chk("t2_d_first", 32'({d_ack, pf_ack}), 32'b10);
        tick(); d_req = 1'b0;
        tick(); pf_req = 1'b0;
        chk("t2_pf_addr", 32'(mem_addr), 32'h0200);
        rsp_valid = 1'b1; rsp_data = 16'h12AB; tick();
        chk("t2_d_rdata", 32'({d_rvalid, d_rdata}), 32'h100AB);
        rsp_data = 16'h3456; tick(); rsp_valid = 1'b0;
        chk("t2_pf_rdata", 32'({pf_rvalid, pf_rdata}), 32'h13456);
        tick();

        // Continuous stores with a waiting prefetch: 3 data grants then 1 fetch
        pf_req = 1'b1; pf_addr = 16'h0300;
        d_req = 1'b1; d_we = 1'b1; d_wide = 1'b1; d_addr = 16'h0400; d_wdata = 16'h5A5A;
        for (int i = 0; i < 12; i++) begin
            #1 chk("t3_pf_turn", 32'(pf_ack), 32'((i % 4) == 3));
            tick();
            if (m_d_g) begin d_addr = d_addr + 16'd2; d_wdata = 16'($urandom); end
            if (m_pf_g) pf_addr = pf_addr + 16'd2;
        end
        drain();

        // Full FIFO blocks fetches and loads but not stores
        pf_req = 1'b1; pf_addr = 16'h0500;
        for (int i = 0; i < 4; i++) begin tick(); pf_addr = pf_addr + 16'd2; end
        chk("t4_outstanding", 32'(outstanding), 32'd4);
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 16'h0600;
        #1 chk("t4_pf_blocked", 32'(pf_ack), 32'd0);
        chk("t4_load_blocked", 32'(d_ack), 32'd0);
        tick(); d_req = 1'b0; tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0602; d_wdata = 16'h1234;
        #1 chk("t4_store", 32'(d_ack), 32'd1);
        tick();
        drain();

        // Flush together with the first of three fetch responses
        pf_req = 1'b1; pf_addr = 16'h0700;
        for (int i = 0; i < 3; i++) begin tick(); pf_addr = pf_addr + 16'd2; end
        pf_req = 1'b0;
        pf_flush = 1'b1; rsp_valid = 1'b1; rsp_data = 16'hAAAA; tick(); pf_flush = 1'b0;
        chk("t5_drop0", 32'(pf_rvalid), 32'd0);
        rsp_data = 16'hBBBB; tick(); chk("t5_drop1", 32'(pf_rvalid), 32'd0);
        rsp_data = 16'hCCCC; tick(); chk("t5_drop2", 32'(pf_rvalid), 32'd0);
        rsp_valid = 1'b0;
        chk("t5_outstanding", 32'(outstanding), 32'd0);
        tick();
        pf_req = 1'b1; pf_addr = 16'h0800; tick(); pf_req = 1'b0; tick();
        rsp_valid = 1'b1; rsp_data = 16'h4321; tick(); rsp_valid = 1'b0;
        chk("t5_after_flush", 32'({pf_rvalid, pf_rdata}), 32'h14321);
        tick();

        // Stalled port holds its fields and blocks new grants
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b1; d_addr = 16'h0900;
        tick(); d_req = 1'b0;
        pf_req = 1'b1; pf_addr = 16'h0A00;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t6_no_ack", 32'(pf_ack), 32'd0);
            chk("t6_hold_addr", 32'(mem_addr), 32'h0900);
            tick();
        end
        mem_ready = 1'b1;
        #1 chk("t6_release", 32'(pf_ack), 32'd1);
        tick();
        drain();
        rsp_valid = 1'b1; rsp_data = 16'hDEAD; tick(); rsp_valid = 1'b0;
        chk("t6_rsp_err", 32'(rsp_err), 32'd1);
        chk("t6_empty", 32'(outstanding), 32'd0);
        tick();
        chk("t6_err_pulse", 32'(rsp_err), 32'd0);

        // Reset in the middle of a stalled transaction
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_wide = 1'b0; d_addr = 16'h0B00;
        tick(); d_req = 1'b0; tick();
        chk("t7_pre", 32'({mem_valid, outstanding}), 32'b1001);
        #3 reset = 1'b1;
        #1;
        chk("t7_mem", 32'({mem_valid, mem_we, mem_wide, mem_addr}), 32'd0);
        chk("t7_outstanding", 32'(outstanding), 32'd0);
        chk("t7_misc", 32'({pf_ack, d_ack, pf_rvalid, d_rvalid, rsp_err}), 32'd0);
        m_fifo.delete(); mem_q.delete(); pf_q.delete(); d_q.delete();
        m_err_pend = 0; m_busy = 1'b0; m_streak = 0;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b1;

        // Randomized traffic following the request hold protocol
        for (int n = 0; n < 800; n++) begin
            if (!pf_req || m_pf_g) begin
                pf_req  = ($urandom_range(0, 1) == 1);
                pf_addr = 16'($urandom);
            end
            if (!d_req || m_d_g) begin
                d_req   = ($urandom_range(0, 1) == 1);
                d_we    = ($urandom_range(0, 1) == 1);
                d_wide  = ($urandom_range(0, 1) == 1);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
            pf_flush  = ($urandom_range(0, 15) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = (m_fifo.size() > 0) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 40) == 0);
            rsp_data  = 16'($urandom);
            tick();
        end
        drain();
        repeat (3) tick();
        chk("end_mem_q", 32'(mem_q.size()), 32'd0);
        chk("end_pf_q", 32'(pf_q.size()), 32'd0);
        chk("end_d_q", 32'(d_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
